// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU slot timer: FSM encoding, register-file
// addresses and TPU_CONTROL bit positions.
package tpu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tpu_state_e;

  // TPU register-file map
  localparam logic [7:0] TPU_CONTROL_ADDR     = 8'h20;
  localparam logic [7:0] TPU_TX_SLOT_ADDR     = 8'h21;
  localparam logic [7:0] TPU_RX_SLOT_ADDR     = 8'h22;
  localparam logic [7:0] TPU_TIMER_VAL_LO_ADDR = 8'h23;
  localparam logic [7:0] TPU_TIMER_VAL_HI_ADDR = 8'h24;

  // TPU_CONTROL bit positions
  localparam int CTRL_RSTTPU_BIT      = 0;
  localparam int CTRL_TXSLOT_EN_BIT   = 1;
  localparam int CTRL_RXSLOT_EN_BIT   = 2;
  localparam int CTRL_TIMERINTMSK_BIT = 3;
  localparam int CTRL_INTFLAG_BIT     = 4;

endpackage

// File: rtl/tpu_prescaler.sv
// Divides SYS_CLK into timer ticks: counts 0..PRESCALE-1 while enabled and
// flags the last count as a tick.
module tpu_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic SYS_CLK,
  input  logic SYS_RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  // next count: clear has priority, otherwise wrap at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tpu_slot_timer.sv
// TDMA slot timer: counts prescaled ticks into slots, produces slot strobes,
// TX/RX slot windows and the TPU timer interrupt.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped (soft reset or TIMER_INT_VALUE==0); counters held 0
//   RUN   | counting ticks and slots
module tpu_slot_timer
  import tpu_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int NUM_SLOTS = 8
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        RSTTPU,
  input  logic        TXSLOT_EN,
  input  logic        RXSLOT_EN,
  input  logic        TIMERINTMSK,
  input  logic        INTFLAG,
  input  logic [7:0]  TX_SLOT,
  input  logic [7:0]  RX_SLOT,
  input  logic [15:0] TIMER_INT_VALUE,
  output logic [15:0] timer_cnt,
  output logic [7:0]  slot_cnt,
  output logic        slot_start,
  output logic        tx_active,
  output logic        rx_active,
  output logic        tx_start,
  output logic        rx_start,
  output logic        irq_pending,
  output logic        irq
);

  localparam logic [7:0] LAST_SLOT = 8'(NUM_SLOTS - 1);

  tpu_state_e  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  slot_q, slot_d;
  logic        slot_start_q, tx_q, rx_q, tx_start_q, rx_start_q;
  logic        tx_d, rx_d;
  logic        pend_q, pend_d;
  logic        intflag_q;
  logic        run_d, running, enter_run, tick, wrap;

  assign run_d     = ~RSTTPU & (TIMER_INT_VALUE != 16'd0);
  assign state_d   = run_d ? RUN : IDLE;
  assign running   = (state_q == RUN);
  assign enter_run = ~running & run_d;
  // >= so that lowering TIMER_INT_VALUE mid-slot ends the slot on the next tick
  assign wrap      = running & run_d & tick & (timer_q >= TIMER_INT_VALUE);

  tpu_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .SYS_CLK (SYS_CLK),
    .SYS_RST (SYS_RST),
    .clr     (~run_d),
    .en      (running),
    .tick    (tick)
  );

  // tick/slot counters, zeroed whenever the timer is not running next cycle
  always_comb begin
    timer_d = timer_q;
    slot_d  = slot_q;
    if (!run_d) begin
      timer_d = '0;
      slot_d  = '0;
    end else if (wrap) begin
      timer_d = '0;
      slot_d  = (slot_q == LAST_SLOT) ? 8'd0 : slot_q + 8'd1;
    end else if (running && tick) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // windows follow the next slot index; out-of-range slots never match
  always_comb begin
    tx_d = run_d & TXSLOT_EN & (slot_d == TX_SLOT);
    rx_d = run_d & RXSLOT_EN & (slot_d == RX_SLOT);
  end

  // sticky interrupt: soft reset blocks everything, set beats clear
  always_comb begin
    pend_d = pend_q;
    if (RSTTPU)                     pend_d = 1'b0;
    else if (wrap)                  pend_d = 1'b1;
    else if (INTFLAG && !intflag_q) pend_d = 1'b0;
  end

  // state and output registers
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      slot_q       <= '0;
      slot_start_q <= 1'b0;
      tx_q         <= 1'b0;
      rx_q         <= 1'b0;
      tx_start_q   <= 1'b0;
      rx_start_q   <= 1'b0;
      pend_q       <= 1'b0;
      intflag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      slot_q       <= slot_d;
      slot_start_q <= enter_run | wrap;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      tx_start_q   <= tx_d & ~tx_q;
      rx_start_q   <= rx_d & ~rx_q;
      pend_q       <= pend_d;
      intflag_q    <= INTFLAG;
    end
  end

  assign timer_cnt   = timer_q;
  assign slot_cnt    = slot_q;
  assign slot_start  = slot_start_q;
  assign tx_active   = tx_q;
  assign rx_active   = rx_q;
  assign tx_start    = tx_start_q;
  assign rx_start    = rx_start_q;
  assign irq_pending = pend_q;
  assign irq         = pend_q & ~TIMERINTMSK;

endmodule
